// File: rtl/alut_mp_pkg.sv
// Shared register map, interrupt bit indices, command encodings and the
// history FIFO entry layout for the multi-port ALUT register bank.
package alut_mp_pkg;

  // APB byte addresses of the register bank
  typedef enum logic [6:0] {
    ADDR_FRM_D_L        = 7'h00,
    ADDR_FRM_D_U        = 7'h04,
    ADDR_FRM_S_L        = 7'h08,
    ADDR_FRM_S_U        = 7'h0C,
    ADDR_S_PORT         = 7'h10,
    ADDR_D_PORT         = 7'h14,
    ADDR_MAC_L          = 7'h18,
    ADDR_MAC_U          = 7'h1C,
    ADDR_CUR_TIME       = 7'h20,
    ADDR_BB_AGE         = 7'h24,
    ADDR_DIV_CLK        = 7'h28,
    ADDR_COMMAND        = 7'h2C,
    ADDR_STATUS         = 7'h30,
    ADDR_LST_INV_ADDR_L = 7'h34,
    ADDR_LST_INV_ADDR_U = 7'h38,
    ADDR_LST_INV_PORT   = 7'h3C,
    ADDR_FIFO_STAT      = 7'h40,
    ADDR_INT_EN         = 7'h44,
    ADDR_INT_STAT       = 7'h48
  } reg_addr_e;

  // INT_STAT / INT_EN bit positions
  localparam int unsigned INT_REUSED   = 0;
  localparam int unsigned INT_INV_DONE = 1;
  localparam int unsigned INT_OVF      = 2;
  localparam int unsigned INT_CMD_REJ  = 3;
  localparam int unsigned INT_W        = 4;

  // Checker command encodings
  typedef enum logic [1:0] {
    CMD_NONE     = 2'b00,
    CMD_INV_AGED = 2'b01,
    CMD_RSVD2    = 2'b10,
    CMD_RSVD3    = 2'b11
  } cmd_e;

  // Port field is sized for the largest supported switch; narrower
  // configurations use the low PORT_W bits and leave the rest zero.
  localparam int unsigned PORT_MAX_W = 8;

  typedef struct packed {
    logic [47:0]           addr;
    logic [PORT_MAX_W-1:0] port;
  } inv_entry_t;

endpackage

// File: rtl/alut_inv_hist_fifo.sv
// Last-invalidated history FIFO: synchronous, power-of-2 depth, discards a
// push when full (unless a pop happens in the same cycle) and flags it.
module alut_inv_hist_fifo
  import alut_mp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             pclk,
  input  logic             p_reset,
  input  logic             push,
  input  inv_entry_t       push_data,
  input  logic             pop,
  input  logic             ovf_clr,
  output inv_entry_t       head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             ovf_evt
);

  localparam int unsigned AW = $clog2(DEPTH);

  inv_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push at full still lands
  assign do_push = push & (~full | do_pop);
  assign ovf_evt = push & full & ~do_pop;
  assign head    = mem[rd_ptr];

  // Pointer, level and sticky overflow bookkeeping
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: ;
      endcase
      if (ovf_evt)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Entry storage; contents are only visible when the FIFO is non-empty
  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alut_reg_bank_mp.sv
// APB register bank for the multi-port ALUT: checker configuration, status,
// guarded command pulse, last-invalidated history and maskable interrupt.
module alut_reg_bank_mp
  import alut_mp_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned PORT_W     = $clog2(NUM_PORTS),
  parameter int unsigned HIST_DEPTH = 4,
  parameter int unsigned DIV_W      = 8,
  parameter logic [31:0] BBA_RST    = 32'hFFFF_FFFF
) (
  input  logic                 pclk,
  input  logic                 p_reset,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [6:0]           paddr,
  input  logic [31:0]          pwdata,
  input  logic [31:0]          curr_time,
  input  logic                 add_check_active,
  input  logic                 age_check_active,
  input  logic                 inval_in_prog,
  input  logic                 reused,
  input  logic [NUM_PORTS:0]   d_port,
  input  logic [47:0]          lst_inv_addr_nrm,
  input  logic [47:0]          lst_inv_addr_cmd,
  input  logic [PORT_W-1:0]    lst_inv_port_nrm,
  input  logic [PORT_W-1:0]    lst_inv_port_cmd,
  output logic [47:0]          mac_addr,
  output logic [47:0]          d_addr,
  output logic [47:0]          s_addr,
  output logic [PORT_W-1:0]    s_port,
  output logic [31:0]          best_bfr_age,
  output logic [DIV_W-1:0]     div_clk,
  output logic [1:0]           command,
  output logic [31:0]          prdata,
  output logic                 clear_reused,
  output logic                 irq
);

  localparam int unsigned LVL_W = $clog2(HIST_DEPTH + 1);

  logic             read_en;
  logic             write_en;
  logic             active;
  logic             cmd_wr;
  logic             cmd_ok;
  logic             cmd_acc;
  logic             cmd_rej;
  logic [INT_W-1:0] int_en;
  logic [INT_W-1:0] int_stat;
  logic [INT_W-1:0] int_set;
  logic [INT_W-1:0] int_w1c;
  logic [31:0]      rd_mux;

  logic             inval_d;
  logic             inval_fall;
  logic             pend_v;
  logic             cmd_req;
  logic             pend_cap;
  inv_entry_t       pend_entry;
  inv_entry_t       nrm_entry;
  inv_entry_t       cmd_entry;
  inv_entry_t       push_entry;
  inv_entry_t       head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_ovf;
  logic             ovf_evt;
  logic             ovf_clr;
  logic [LVL_W-1:0] fifo_level;
  logic             unused_hi;

  assign read_en      = psel & ~penable & ~pwrite;
  assign write_en     = psel & penable & pwrite;
  assign active       = add_check_active | age_check_active;
  assign clear_reused = read_en & (paddr == ADDR_STATUS) & ~active;

  assign cmd_wr  = write_en & (paddr == ADDR_COMMAND) & (pwdata[1:0] != CMD_NONE);
  assign cmd_ok  = ~active & ~inval_in_prog & (command == CMD_NONE);
  assign cmd_acc = cmd_wr & cmd_ok;
  assign cmd_rej = cmd_wr & ~cmd_ok;

  assign inval_fall = inval_d & ~inval_in_prog;
  assign cmd_req    = inval_fall | pend_v;
  assign fifo_pop   = read_en & (paddr == ADDR_LST_INV_PORT) & ~fifo_empty;
  assign ovf_clr    = write_en & (paddr == ADDR_FIFO_STAT) & pwdata[31];

  // Only one push per cycle: a normal (reused) entry always wins and a
  // colliding command entry waits in the one-deep pending register. A new
  // invalidation end is captured whenever exactly one of reused/pending
  // occupies the push slot this cycle.
  assign pend_cap = inval_fall & (reused ^ pend_v);

  // Build FIFO entries and select the single push source
  always_comb begin
    nrm_entry                   = '0;
    nrm_entry.addr              = lst_inv_addr_nrm;
    nrm_entry.port[PORT_W-1:0]  = lst_inv_port_nrm;
    cmd_entry                   = '0;
    cmd_entry.addr              = lst_inv_addr_cmd;
    cmd_entry.port[PORT_W-1:0]  = lst_inv_port_cmd;
    fifo_push                   = reused | cmd_req;
    if (reused)      push_entry = nrm_entry;
    else if (pend_v) push_entry = pend_entry;
    else             push_entry = cmd_entry;
  end

  // Interrupt set sources and write-one-to-clear mask
  always_comb begin
    int_set               = '0;
    int_set[INT_REUSED]   = reused;
    int_set[INT_INV_DONE] = inval_fall;
    int_set[INT_OVF]      = ovf_evt;
    int_set[INT_CMD_REJ]  = cmd_rej;
    int_w1c               = '0;
    if (write_en && (paddr == ADDR_INT_STAT)) int_w1c = pwdata[INT_W-1:0];
  end

  alut_inv_hist_fifo #(
    .DEPTH (HIST_DEPTH),
    .LVL_W (LVL_W)
  ) u_hist (
    .pclk      (pclk),
    .p_reset   (p_reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .ovf_clr   (ovf_clr),
    .head      (head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf),
    .ovf_evt   (ovf_evt)
  );

  // Upper port-field bits of the head are always zero by construction
  assign unused_hi = ^{head.port, fifo_full};

  // Invalidation edge detect and pending command-entry register
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      inval_d    <= 1'b0;
      pend_v     <= 1'b0;
      pend_entry <= '0;
    end else begin
      inval_d <= inval_in_prog;
      pend_v  <= reused ? cmd_req : (pend_v & inval_fall);
      if (pend_cap) pend_entry <= cmd_entry;
    end
  end

  // Configuration registers, command pulse and interrupt state
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      mac_addr     <= '0;
      d_addr       <= '0;
      s_addr       <= '0;
      s_port       <= '0;
      best_bfr_age <= BBA_RST;
      div_clk      <= '0;
      command      <= CMD_NONE;
      int_en       <= '0;
      int_stat     <= '0;
      irq          <= 1'b0;
    end else begin
      command  <= cmd_acc ? pwdata[1:0] : CMD_NONE;
      int_stat <= (int_stat & ~int_w1c) | int_set;
      irq      <= |(int_stat & int_en);
      if (write_en) begin
        case (paddr)
          ADDR_FRM_D_L: d_addr[31:0]   <= pwdata;
          ADDR_FRM_D_U: d_addr[47:32]  <= pwdata[15:0];
          ADDR_FRM_S_L: s_addr[31:0]   <= pwdata;
          ADDR_FRM_S_U: s_addr[47:32]  <= pwdata[15:0];
          ADDR_S_PORT:  s_port         <= pwdata[PORT_W-1:0];
          ADDR_MAC_L:   mac_addr[31:0] <= pwdata;
          ADDR_MAC_U:   mac_addr[47:32] <= pwdata[15:0];
          ADDR_BB_AGE:  best_bfr_age   <= pwdata;
          ADDR_DIV_CLK: div_clk        <= pwdata[DIV_W-1:0];
          ADDR_INT_EN:  int_en         <= pwdata[INT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Read-data multiplexer; unmapped and RO-reserved bits read zero
  always_comb begin
    rd_mux = '0;
    case (paddr)
      ADDR_FRM_D_L:  rd_mux                  = d_addr[31:0];
      ADDR_FRM_D_U:  rd_mux[15:0]            = d_addr[47:32];
      ADDR_FRM_S_L:  rd_mux                  = s_addr[31:0];
      ADDR_FRM_S_U:  rd_mux[15:0]            = s_addr[47:32];
      ADDR_S_PORT:   rd_mux[PORT_W-1:0]      = s_port;
      ADDR_D_PORT:   rd_mux[NUM_PORTS:0]     = d_port;
      ADDR_MAC_L:    rd_mux                  = mac_addr[31:0];
      ADDR_MAC_U:    rd_mux[15:0]            = mac_addr[47:32];
      ADDR_CUR_TIME: rd_mux                  = curr_time;
      ADDR_BB_AGE:   rd_mux                  = best_bfr_age;
      ADDR_DIV_CLK:  rd_mux[DIV_W-1:0]       = div_clk;
      ADDR_COMMAND:  rd_mux[1:0]             = command;
      ADDR_STATUS:   rd_mux[3:0]             = {~fifo_empty, reused, inval_in_prog, active};
      ADDR_LST_INV_ADDR_L: if (!fifo_empty) rd_mux       = head.addr[31:0];
      ADDR_LST_INV_ADDR_U: if (!fifo_empty) rd_mux[15:0] = head.addr[47:32];
      ADDR_LST_INV_PORT: begin
        if (!fifo_empty) begin
          rd_mux[31]           = 1'b1;
          rd_mux[PORT_W-1:0]   = head.port[PORT_W-1:0];
        end
      end
      ADDR_FIFO_STAT: begin
        rd_mux[31]          = fifo_ovf;
        rd_mux[LVL_W-1:0]   = fifo_level;
      end
      ADDR_INT_EN:   rd_mux[INT_W-1:0]       = int_en;
      ADDR_INT_STAT: rd_mux[INT_W-1:0]       = int_stat;
      default: ;
    endcase
  end

  // Registered APB read data, zero outside the read setup cycle
  always_ff @(posedge pclk) begin
    if (p_reset) prdata <= '0;
    else         prdata <= read_en ? rd_mux : '0;
  end

endmodule

// File: tb/tb_alut_reg_bank_mp.sv
module tb_alut_reg_bank_mp;

  localparam int unsigned NP = 8;
  localparam int unsigned PW = 3;
  localparam int unsigned HD = 4;
  localparam int unsigned DW = 8;

  logic          pclk = 1'b0;
  logic          p_reset, psel, penable, pwrite;
  logic [6:0]    paddr;
  logic [31:0]   pwdata, curr_time;
  logic          add_check_active, age_check_active, inval_in_prog, reused;
  logic [NP:0]   d_port;
  logic [47:0]   lst_inv_addr_nrm, lst_inv_addr_cmd;
  logic [PW-1:0] lst_inv_port_nrm, lst_inv_port_cmd;
  logic [47:0]   mac_addr, d_addr, s_addr;
  logic [PW-1:0] s_port;
  logic [31:0]   best_bfr_age;
  logic [DW-1:0] div_clk;
  logic [1:0]    command;
  logic [31:0]   prdata;
  logic          clear_reused, irq;

  alut_reg_bank_mp #(
    .NUM_PORTS  (NP),
    .HIST_DEPTH (HD),
    .DIV_W      (DW),
    .BBA_RST    (32'hFFFF_FFFF)
  ) dut (
    .pclk (pclk), .p_reset (p_reset), .psel (psel), .penable (penable),
    .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .curr_time (curr_time),
    .add_check_active (add_check_active), .age_check_active (age_check_active),
    .inval_in_prog (inval_in_prog), .reused (reused), .d_port (d_port),
    .lst_inv_addr_nrm (lst_inv_addr_nrm), .lst_inv_addr_cmd (lst_inv_addr_cmd),
    .lst_inv_port_nrm (lst_inv_port_nrm), .lst_inv_port_cmd (lst_inv_port_cmd),
    .mac_addr (mac_addr), .d_addr (d_addr), .s_addr (s_addr), .s_port (s_port),
    .best_bfr_age (best_bfr_age), .div_clk (div_clk), .command (command),
    .prdata (prdata), .clear_reused (clear_reused), .irq (irq)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: history as queues, interrupt/overflow as plain bits
  logic [47:0]   q_addr [$];
  logic [PW-1:0] q_port [$];
  logic          m_ovf;
  logic [3:0]    m_int_stat;
  logic [3:0]    m_int_en;

  task automatic model_clear();
    q_addr.delete(); q_port.delete();
    m_ovf = 1'b0; m_int_stat = 4'h0; m_int_en = 4'h0;
  endtask

  task automatic model_push(input logic [47:0] a, input logic [PW-1:0] p);
    if (q_addr.size() < HD) begin
      q_addr.push_back(a); q_port.push_back(p);
    end else begin
      m_ovf = 1'b1; m_int_stat[2] = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_port_reg();
    logic [31:0] e;
    e = 32'h0;
    if (q_addr.size() > 0) begin e[31] = 1'b1; e[PW-1:0] = q_port[0]; end
    return e;
  endfunction

  function automatic logic [31:0] exp_fifo_stat();
    logic [31:0] e;
    e = 32'(q_addr.size());
    e[31] = m_ovf;
    return e;
  endfunction

  task automatic apb_write(input logic [6:0] a, input logic [31:0] d);
    @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [6:0] a, output logic [31:0] d);
    @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk); d = prdata; penable = 1'b1;
    @(negedge pclk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pulse_reused(input logic [47:0] a, input logic [PW-1:0] p);
    @(negedge pclk); reused = 1'b1; lst_inv_addr_nrm = a; lst_inv_port_nrm = p;
    @(negedge pclk); reused = 1'b0;
    model_push(a, p); m_int_stat[0] = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    p_reset = 1'b1;
    repeat (3) @(negedge pclk);
    p_reset = 1'b0;
    model_clear();
    n_checks++; if (best_bfr_age !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_bba: got %h want ffffffff", best_bfr_age); end
    n_checks++; if ({mac_addr, d_addr, s_addr} !== 144'h0) begin n_fail++; $display("FAIL rst_addr: got %h/%h/%h want 0", mac_addr, d_addr, s_addr); end
    n_checks++; if ({s_port, div_clk, command} !== 13'h0) begin n_fail++; $display("FAIL rst_misc: got %h %h %h want 0", s_port, div_clk, command); end
    n_checks++; if ({prdata, irq, clear_reused} !== 34'h0) begin n_fail++; $display("FAIL rst_out: got %h %b %b want 0", prdata, irq, clear_reused); end
    apb_read(7'h24, r);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rd_bba: got %h want ffffffff", r); end
    apb_read(7'h10, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rd_sport_rst: got %h want 0", r); end
    apb_read(7'h40, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rd_fifo_rst: got %h want 0", r); end
  endtask

  task automatic test_regs();
    logic [6:0]  ra [10];
    logic [31:0] rm [10];
    logic [31:0] sh [10];
    logic [31:0] r, d;
    int unsigned idx;
    ra = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h10, 7'h18, 7'h1C, 7'h24, 7'h28, 7'h44};
    rm = '{32'hFFFF_FFFF, 32'hFFFF, 32'hFFFF_FFFF, 32'hFFFF, 32'h7,
           32'hFFFF_FFFF, 32'hFFFF, 32'hFFFF_FFFF, 32'hFF, 32'hF};
    sh = '{default: 32'h0};
    sh[7] = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      idx = $urandom_range(9, 0);
      d = $urandom;
      apb_write(ra[idx], d);
      sh[idx] = d & rm[idx];
      apb_read(ra[idx], r);
      n_checks++; if (r !== sh[idx]) begin n_fail++; $display("FAIL reg_rb@%h: got %h want %h", ra[idx], r, sh[idx]); end
    end
    m_int_en = sh[9][3:0];
    n_checks++; if (d_addr !== {sh[1][15:0], sh[0]}) begin n_fail++; $display("FAIL d_addr: got %h want %h", d_addr, {sh[1][15:0], sh[0]}); end
    n_checks++; if (s_addr !== {sh[3][15:0], sh[2]}) begin n_fail++; $display("FAIL s_addr: got %h want %h", s_addr, {sh[3][15:0], sh[2]}); end
    n_checks++; if (mac_addr !== {sh[6][15:0], sh[5]}) begin n_fail++; $display("FAIL mac_addr: got %h want %h", mac_addr, {sh[6][15:0], sh[5]}); end
    n_checks++; if (s_port !== sh[4][PW-1:0]) begin n_fail++; $display("FAIL s_port: got %h want %h", s_port, sh[4][PW-1:0]); end
    n_checks++; if (best_bfr_age !== sh[7]) begin n_fail++; $display("FAIL bba: got %h want %h", best_bfr_age, sh[7]); end
    n_checks++; if (div_clk !== sh[8][DW-1:0]) begin n_fail++; $display("FAIL div_clk: got %h want %h", div_clk, sh[8][DW-1:0]); end
    d = $urandom;
    apb_write(7'h50, d);
    apb_read(7'h50, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL unmapped: got %h want 0", r); end
  endtask

  task automatic test_status();
    logic [31:0] r, e;
    d_port = 9'($urandom); curr_time = $urandom;
    apb_write(7'h14, $urandom);
    apb_read(7'h14, r);
    e = 32'(d_port);
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL d_port_rd: got %h want %h", r, e); end
    apb_read(7'h20, r);
    n_checks++; if (r !== curr_time) begin n_fail++; $display("FAIL cur_time: got %h want %h", r, curr_time); end
    for (int a = 0; a < 2; a++) begin
      add_check_active = a[0];
      @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 7'h30;
      #1;
      n_checks++; if (clear_reused !== ~a[0]) begin n_fail++; $display("FAIL clear_reused: got %b want %b", clear_reused, ~a[0]); end
      @(negedge pclk);
      n_checks++; if (prdata !== 32'(a)) begin n_fail++; $display("FAIL status: got %h want %h", prdata, 32'(a)); end
      penable = 1'b1;
      @(negedge pclk); psel = 1'b0; penable = 1'b0;
    end
    add_check_active = 1'b0;
  endtask

  task automatic test_command();
    logic [31:0] r;
    logic [1:0]  c;
    apb_write(7'h44, 32'h8); m_int_en = 4'h8;
    for (int i = 0; i < 3; i++) begin
      c = (i == 0) ? 2'b01 : 2'($urandom_range(3, 1));
      apb_write(7'h2C, {$urandom_range(255, 0), 22'h0, c});
      n_checks++; if (command !== c) begin n_fail++; $display("FAIL cmd_pulse: got %b want %b", command, c); end
      @(negedge pclk);
      n_checks++; if (command !== 2'b00) begin n_fail++; $display("FAIL cmd_one_cycle: got %b want 00", command); end
    end
    apb_write(7'h2C, 32'h0);
    n_checks++; if (command !== 2'b00) begin n_fail++; $display("FAIL cmd_zero: got %b want 00", command); end
    age_check_active = 1'b1;
    apb_write(7'h2C, 32'h1);
    m_int_stat[3] = 1'b1;
    n_checks++; if (command !== 2'b00) begin n_fail++; $display("FAIL cmd_rej: got %b want 00", command); end
    @(negedge pclk);
    n_checks++; if (irq !== |(m_int_stat & m_int_en)) begin n_fail++; $display("FAIL irq_rej: got %b want %b", irq, |(m_int_stat & m_int_en)); end
    apb_read(7'h48, r);
    n_checks++; if (r !== 32'(m_int_stat)) begin n_fail++; $display("FAIL int_stat_rej: got %h want %h", r, m_int_stat); end
    age_check_active = 1'b0;
    apb_write(7'h48, 32'h8); m_int_stat[3] = 1'b0;
    @(negedge pclk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b want 0", irq); end
    apb_read(7'h48, r);
    n_checks++; if (r !== 32'(m_int_stat)) begin n_fail++; $display("FAIL int_stat_w1c: got %h want %h", r, m_int_stat); end
  endtask

  task automatic test_fifo_basic();
    logic [31:0] r;
    pulse_reused(48'h1122_3344_5566, 3'd2);
    apb_read(7'h34, r);
    n_checks++; if (r !== 32'h3344_5566) begin n_fail++; $display("FAIL hist_l: got %h want 33445566", r); end
    apb_read(7'h38, r);
    n_checks++; if (r !== 32'h1122) begin n_fail++; $display("FAIL hist_u: got %h want 00001122", r); end
    apb_read(7'h3C, r);
    n_checks++; if (r !== 32'h8000_0002) begin n_fail++; $display("FAIL hist_port: got %h want 80000002", r); end
    void'(q_addr.pop_front()); void'(q_port.pop_front());
    apb_read(7'h3C, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL hist_empty: got %h want 0", r); end
    apb_read(7'h34, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL hist_l_empty: got %h want 0", r); end
    apb_read(7'h48, r);
    n_checks++; if (r !== 32'(m_int_stat)) begin n_fail++; $display("FAIL int_reused: got %h want %h", r, m_int_stat); end
    apb_write(7'h48, 32'hF); m_int_stat = 4'h0;
  endtask

  task automatic test_overflow();
    logic [31:0] r, e;
    logic [47:0] a;
    logic [PW-1:0] p;
    for (int i = 0; i < 5; i++) pulse_reused({$urandom, $urandom} >> 16, 3'($urandom));
    apb_read(7'h40, r);
    n_checks++; if (r !== exp_fifo_stat()) begin n_fail++; $display("FAIL ovf_stat: got %h want %h", r, exp_fifo_stat()); end
    apb_read(7'h48, r);
    n_checks++; if (r !== 32'(m_int_stat)) begin n_fail++; $display("FAIL ovf_int: got %h want %h", r, m_int_stat); end
    apb_read(7'h34, r);
    n_checks++; if (r !== q_addr[0][31:0]) begin n_fail++; $display("FAIL ovf_head: got %h want %h", r, q_addr[0][31:0]); end
    apb_write(7'h40, 32'h8000_0000); m_ovf = 1'b0;
    apb_write(7'h48, 32'h4); m_int_stat[2] = 1'b0;
    a = {$urandom, $urandom} >> 16; p = 3'($urandom);
    e = exp_port_reg();
    @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 7'h3C;
    reused = 1'b1; lst_inv_addr_nrm = a; lst_inv_port_nrm = p;
    @(negedge pclk);
    n_checks++; if (prdata !== e) begin n_fail++; $display("FAIL popush_rd: got %h want %h", prdata, e); end
    reused = 1'b0; penable = 1'b1;
    @(negedge pclk); psel = 1'b0; penable = 1'b0;
    void'(q_addr.pop_front()); void'(q_port.pop_front());
    model_push(a, p); m_int_stat[0] = 1'b1;
    apb_read(7'h40, r);
    n_checks++; if (r !== exp_fifo_stat()) begin n_fail++; $display("FAIL popush_stat: got %h want %h", r, exp_fifo_stat()); end
    apb_read(7'h48, r);
    n_checks++; if (r !== 32'(m_int_stat)) begin n_fail++; $display("FAIL popush_int: got %h want %h", r, m_int_stat); end
    for (int i = 0; i < HD; i++) begin
      apb_read(7'h34, r);
      n_checks++; if (r !== q_addr[0][31:0]) begin n_fail++; $display("FAIL drain_l%0d: got %h want %h", i, r, q_addr[0][31:0]); end
      apb_read(7'h38, r);
      n_checks++; if (r !== {16'h0, q_addr[0][47:32]}) begin n_fail++; $display("FAIL drain_u%0d: got %h want %h", i, r, q_addr[0][47:32]); end
      e = exp_port_reg();
      apb_read(7'h3C, r);
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL drain_p%0d: got %h want %h", i, r, e); end
      void'(q_addr.pop_front()); void'(q_port.pop_front());
    end
    apb_read(7'h40, r);
    n_checks++; if (r !== exp_fifo_stat()) begin n_fail++; $display("FAIL drain_stat: got %h want %h", r, exp_fifo_stat()); end
    apb_write(7'h48, 32'hF); m_int_stat = 4'h0;
  endtask

  // Invalidation end and reused pulse land in the same cycle
  task automatic dual_event(output logic [47:0] an, output logic [PW-1:0] pn,
                            output logic [47:0] ac, output logic [PW-1:0] pc);
    an = {$urandom, $urandom} >> 16; pn = 3'($urandom);
    ac = {$urandom, $urandom} >> 16; pc = 3'($urandom);
    @(negedge pclk); inval_in_prog = 1'b1; lst_inv_addr_cmd = ac; lst_inv_port_cmd = pc;
    @(negedge pclk);
    @(negedge pclk); inval_in_prog = 1'b0; reused = 1'b1; lst_inv_addr_nrm = an; lst_inv_port_nrm = pn;
    @(negedge pclk); reused = 1'b0; lst_inv_addr_cmd = ~ac; lst_inv_port_cmd = ~pc;
  endtask

  task automatic test_dual_event();
    logic [31:0] r, e;
    logic [47:0] an, ac;
    logic [PW-1:0] pn, pc;
    dual_event(an, pn, ac, pc);
    model_push(an, pn); model_push(ac, pc); m_int_stat[1:0] = 2'b11;
    @(negedge pclk);
    apb_read(7'h40, r);
    n_checks++; if (r !== exp_fifo_stat()) begin n_fail++; $display("FAIL dual_stat: got %h want %h", r, exp_fifo_stat()); end
    apb_read(7'h48, r);
    n_checks++; if (r !== 32'(m_int_stat)) begin n_fail++; $display("FAIL dual_int: got %h want %h", r, m_int_stat); end
    for (int i = 0; i < 2; i++) begin
      apb_read(7'h34, r);
      n_checks++; if (r !== q_addr[0][31:0]) begin n_fail++; $display("FAIL dual_l%0d: got %h want %h", i, r, q_addr[0][31:0]); end
      e = exp_port_reg();
      apb_read(7'h3C, r);
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL dual_p%0d: got %h want %h", i, r, e); end
      void'(q_addr.pop_front()); void'(q_port.pop_front());
    end
    n_checks++; if (irq !== |(m_int_stat & m_int_en)) begin n_fail++; $display("FAIL dual_irq: got %b want %b", irq, |(m_int_stat & m_int_en)); end
    apb_write(7'h48, 32'hF); m_int_stat = 4'h0;
  endtask

  task automatic test_reset_pending();
    logic [31:0] r;
    logic [47:0] an, ac;
    logic [PW-1:0] pn, pc;
    inval_in_prog = 1'b1;
    @(negedge pclk);
    @(negedge pclk); inval_in_prog = 1'b0; reused = 1'b1;
    an = {$urandom, $urandom} >> 16; pn = 3'($urandom);
    ac = {$urandom, $urandom} >> 16; pc = 3'($urandom);
    lst_inv_addr_nrm = an; lst_inv_port_nrm = pn; lst_inv_addr_cmd = ac; lst_inv_port_cmd = pc;
    @(negedge pclk); reused = 1'b0; p_reset = 1'b1;
    @(negedge pclk); p_reset = 1'b0;
    model_clear();
    repeat (3) @(negedge pclk);
    apb_read(7'h40, r);
    n_checks++; if (r !== exp_fifo_stat()) begin n_fail++; $display("FAIL rstpend_stat: got %h want %h", r, exp_fifo_stat()); end
    apb_read(7'h3C, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rstpend_port: got %h want 0", r); end
    apb_read(7'h48, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rstpend_int: got %h want 0", r); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rstpend_irq: got %b want 0", irq); end
  endtask

  task automatic test_sport_trunc();
    logic [31:0] r;
    apb_write(7'h10, 32'hFF);
    n_checks++; if (s_port !== 3'b111) begin n_fail++; $display("FAIL sport_out: got %b want 111", s_port); end
    apb_read(7'h10, r);
    n_checks++; if (r !== 32'h7) begin n_fail++; $display("FAIL sport_rd: got %h want 7", r); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    p_reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; curr_time = '0;
    add_check_active = 1'b0; age_check_active = 1'b0;
    inval_in_prog = 1'b0; reused = 1'b0; d_port = '0;
    lst_inv_addr_nrm = '0; lst_inv_addr_cmd = '0;
    lst_inv_port_nrm = '0; lst_inv_port_cmd = '0;
    model_clear();
    test_reset();
    test_regs();
    test_status();
    test_command();
    test_fifo_basic();
    test_overflow();
    test_dual_event();
    test_reset_pending();
    test_sport_trunc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alut_reg_bank_mp.md
Name: alut_reg_bank_mp

Overview:
Parametrised APB register bank for the multi-port ALUT.
- Generalises the 4-port bank in port count, clock-divider width and best-before reset value.
- Adds a last-invalidated history FIFO that pops on read, a guarded command register with rejection, and a maskable interrupt.
- Sits between the APB bridge and the ALUT address/age checkers; all checker configuration and status passes through it.

Parameters:
NUM_PORTS, 4, number of switch ports (min 2).
PORT_W, $clog2(NUM_PORTS), source/invalidated port field width (derived; do not override).
HIST_DEPTH, 4, last-invalidated history FIFO entries (power of 2, min 2).
DIV_W, 8, clock divider width (max 32).
BBA_RST, 32'hFFFF_FFFF, best_bfr_age reset value.

Ports:
pclk  in  1  APB clock, rising edge.
p_reset  in  1  synchronous active-high reset.
psel, penable, pwrite  in  1 each  APB control.
paddr  in  7  byte address.
pwdata  in  32  write data.
curr_time  in  32  current time.
add_check_active, age_check_active  in  1 each  checker busy.
inval_in_prog  in  1  age invalidation running.
reused  in  1  one-cycle pulse: entry overwritten.
d_port  in  NUM_PORTS+1  destination bitmap (MSB = broadcast).
lst_inv_addr_nrm / lst_inv_addr_cmd  in  48 each  invalidated address (normal / command).
lst_inv_port_nrm / lst_inv_port_cmd  in  PORT_W each  invalidated port.
mac_addr, d_addr, s_addr  out  48 each  switch, destination and source addresses.
s_port  out  PORT_W  source port.
best_bfr_age  out  32  age limit.
div_clk  out  DIV_W  divider value.
command  out  2  one-cycle command pulse.
prdata  out  32  read data.
clear_reused  out  1  STATUS read while not active.
irq  out  1  registered interrupt.

Behaviour:
Reset:
- Synchronous on p_reset; all outputs are 0 except best_bfr_age=BBA_RST.
- Reset also clears the FIFO, INT_STAT and INT_EN.

APB protocol:
- read_en = psel&~penable&~pwrite; prdata is registered one cycle later and is 0 in any non-read cycle.
- write_en = psel&penable&pwrite; writes take effect on the next edge.
- Unmapped addresses read 0 and ignore writes.
- Writable registers are truncated to their width; RO bits read 0.

Map, from the shared package:
- 0x00/04 FRM_D_L/U, 0x08/0C FRM_S_L/U, 0x10 S_PORT, 0x14 D_PORT (RO).
- 0x18/1C MAC_L/U, 0x20 CUR_TIME (RO), 0x24 BB_AGE, 0x28 DIV_CLK, 0x2C COMMAND.
- 0x30 STATUS (RO) = {28'0, fifo_nonempty, reused, inval_in_prog, active}, where active = add_check_active|age_check_active.
- 0x34/38 LST_INV_ADDR_L/U show the FIFO head (0 if empty).
- 0x3C LST_INV_PORT = {valid[31], port}; a read with valid=1 pops the FIFO, a read when empty returns 0 with no pop.
- 0x40 FIFO_STAT = {overflow[31], level[7:0]}; write 1 to bit 31 clears overflow.
- 0x44 INT_EN (4 bits, RW).
- 0x48 INT_STAT (W1C): [0] reused, [1] inval_done, [2] overflow, [3] cmd_rej.

Command register:
- A nonzero write is accepted only if ~active & ~inval_in_prog & command==0.
- Accepted: command=pwdata[1:0] for exactly one cycle, then 0.
- Rejected: command stays 0 and INT_STAT[3] is set. A write of 0 is ignored.

History FIFO:
- Push nrm entry when reused=1.
- Push cmd entry on the falling edge of inval_in_prog (registered delay), which also sets INT_STAT[1].
- Both events in one cycle: push nrm; cmd is held in a one-deep pending register and pushed next cycle.
- Full: the new entry is discarded and overflow plus INT_STAT[2] are set.
- Full with pop and push in the same cycle: both succeed, no overflow.
- Level is 0..HIST_DEPTH; pointers wrap modulo HIST_DEPTH.

Interrupts:
- A set event and a W1C in the same cycle: set wins.
- irq = registered |(INT_STAT & INT_EN).

clear_reused = read_en & (paddr==STATUS) & ~active, combinational.

Decomposition:
- Package alut_mp_pkg holds the address constants, INT_STAT bit indices, the command encodings (00 none, 01 invalidate aged, 10/11 reserved) and the FIFO entry struct {addr[47:0], port}.
- Sub-module alut_inv_hist_fifo (parametrised synchronous FIFO: push, pop, head, level, full, overflow).

Test Plan:
- Reset, then read BB_AGE → 0xFFFF_FFFF one cycle after the setup phase; read S_PORT → 0; irq=0.
- Write COMMAND=1 with idle checkers → command=01 for exactly one cycle. Repeat with age_check_active=1 → command stays 0, INT_STAT=0x8, irq=1 if INT_EN[3]=1. W1C 0x8 → irq=0.
- reused pulse with nrm={0x1122_3344_5566, port 2} → LST_INV_ADDR_L=0x3344_5566, U=0x1122. Read LST_INV_PORT → 0x8000_0002; a second read → 0 (empty).
- HIST_DEPTH=4: five reused pulses → level=4, overflow=1, INT_STAT[2]=1. Head is the 1st entry and the 5th is lost. Pop-plus-push at full → level stays 4, no new overflow.
- reused pulse in the same cycle as inval_in_prog falling → two entries, nrm first then cmd, level=2, INT_STAT[1:0]=2'b11.
- NUM_PORTS=8: write S_PORT=0xFF → s_port=3'b111 and reads back 0x7. Assert p_reset during a pending cmd push → FIFO empty and no push afterwards.
